// File: rtl/dev_uart_tx_pkg.sv
// Shared definitions for the UART transmitter: register map, FSM encodings and
// STATUS/CTRL bit positions.
package dev_uart_tx_pkg;

    // Register select values (bridge address bits [3:2])
    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    // Transmit FSM encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // STATUS bit positions
    localparam int unsigned STAT_EMPTY   = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_TX_EN  = 0;
    localparam int unsigned CTRL_INT_EN = 1;

    // A zero divisor would stall the baud counter, so it is promoted to 1.
    function automatic logic [15:0] fix_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/dev_uart_tx_fifo.sv
// Byte-wide synchronous FIFO. A push while full is accepted only when a pop
// frees the head slot in the same cycle; otherwise it is silently dropped and
// the caller decides what to do about it.
module dev_uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy state; reset flushes the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: empty pointers make its contents unreachable
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/dev_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO, programmable baud
// divisor and a level "buffer drained" interrupt.
module dev_uart_tx
    import dev_uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  add,
    input  logic        write_en,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        int_request,
    output logic        tx
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [1:0]      state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [15:0]     div_lat_q, div_lat_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            int_q, int_d;
    logic            tx_en_q, tx_en_d;
    logic            int_en_q, int_en_d;
    logic [15:0]     div_q, div_d;
    logic            ovf_q, ovf_d;

    logic            fifo_push;
    logic            fifo_pop;
    logic [7:0]      fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic [3:0]      cnt4;
    logic            busy;
    logic            unused_data;

    assign unused_data = ^data_in[31:16];

    assign busy      = (state_q != S_IDLE);
    assign fifo_push = write_en && (add == ADDR_TXDATA);
    assign fifo_pop  = (state_q == S_IDLE) && tx_en_q && !fifo_empty;
    assign cnt4      = 4'(fifo_count);

    dev_uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (data_in[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register writes and sticky overflow
    always_comb begin
        tx_en_d  = tx_en_q;
        int_en_d = int_en_q;
        div_d    = div_q;
        ovf_d    = ovf_q;
        if (write_en) begin
            unique case (add)
                ADDR_STATUS: ovf_d = 1'b0;
                ADDR_CTRL: begin
                    tx_en_d  = data_in[CTRL_TX_EN];
                    int_en_d = data_in[CTRL_INT_EN];
                end
                ADDR_DIV:    div_d = fix_div(data_in[15:0]);
                default:     ;
            endcase
        end
        // A push into a full FIFO with no same-cycle pop is lost
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    // Frame sequencer: each state holds for div_lat_q clocks
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        div_lat_d = div_lat_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (fifo_pop) begin
                    shift_d   = fifo_rdata;
                    div_lat_d = div_q;
                    baud_d    = div_q - 16'd1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (baud_q == 16'd0) begin
                    baud_d    = div_lat_q - 16'd1;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d  = div_lat_q - 16'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                if (baud_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
        endcase
    end

    // Line level and interrupt are registered, so tx lags the state by one clock
    always_comb begin
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        int_d = int_en_q && fifo_empty && !busy;
    end

    // All device state; reset forces the line idle immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            div_lat_q <= DEFAULT_DIV;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            int_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            int_en_q  <= 1'b0;
            div_q     <= DEFAULT_DIV;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            div_lat_q <= div_lat_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            int_q     <= int_d;
            tx_en_q   <= tx_en_d;
            int_en_q  <= int_en_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
        end
    end

    // Combinational read mux, free of side effects
    always_comb begin
        data_out = 32'd0;
        unique case (add)
            ADDR_STATUS: begin
                data_out[STAT_EMPTY]                  = fifo_empty;
                data_out[STAT_FULL]                   = fifo_full;
                data_out[STAT_BUSY]                   = busy;
                data_out[STAT_OVF]                    = ovf_q;
                data_out[STAT_CNT_LSB+3:STAT_CNT_LSB] = cnt4;
            end
            ADDR_CTRL: begin
                data_out[CTRL_TX_EN]  = tx_en_q;
                data_out[CTRL_INT_EN] = int_en_q;
            end
            ADDR_DIV:  data_out[15:0] = div_q;
            default:   data_out = 32'd0;
        endcase
    end

    assign tx          = tx_q;
    assign int_request = int_q;

endmodule

// File: tb/tb_dev_uart_tx.sv
// Self-checking bench for dev_uart_tx: bytes pushed are queued as expected
// frames and compared against what is decoded from the tx line.
module tb_dev_uart_tx;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [1:0]  add      = 2'd1;
    logic        write_en = 1'b0;
    logic [31:0] data_in  = 32'd0;
    logic [31:0] data_out;
    logic        int_request;
    logic        tx;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] sb[$];

    dev_uart_tx #(
        .DEPTH       (4),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .add         (add),
        .write_en    (write_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .int_request (int_request),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves the strobe up so consecutive calls give one write per clock
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        add      = a;
        data_in  = d;
        write_en = 1'b1;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        write_en = 1'b0;
        add      = 2'd1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        write_en = 1'b0;
        add      = a;
        #1 v = data_out;
    endtask

    // Waits for tx low, then records n consecutive mid-cycle samples of tx and busy
    task automatic capture(input int n, output logic [127:0] bits,
                           output logic [127:0] busyv, output bit found);
        found = 1'b0;
        bits  = '0;
        busyv = '0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            #1;
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (found) begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    #1;
                end
                bits[i]  = tx;
                busyv[i] = data_out[2];
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_tx_in_reset: got %b expected 1", tx);
        end
        reset = 1'b1;
        bus_read(2'd1, v);
        tests_run++;
        if (v !== 32'h1) begin
            tests_failed++;
            $display("FAIL reset_status: got %h expected 00000001", v);
        end
        bus_read(2'd3, v);
        tests_run++;
        if (v !== 32'd434) begin
            tests_failed++;
            $display("FAIL reset_div: got %0d expected 434", v);
        end
        bus_read(2'd2, v);
        tests_run++;
        if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %h expected 0", v);
        end
        bus_read(2'd0, v);
        tests_run++;
        if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_txdata_read: got %h expected 0", v);
        end
        tests_run++;
        if (tx !== 1'b1 || int_request !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got tx=%b int=%b expected tx=1 int=0", tx, int_request);
        end
    endtask

    task automatic test_single_frame();
        logic [127:0] bits, busyv;
        logic [39:0]  expw;
        logic [7:0]   b;
        logic [31:0]  v;
        bit           found;
        b = 8'hA5;
        expw = '0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) expw[4 + 4*k + j] = b[k];
        end
        for (int j = 36; j < 40; j++) expw[j] = 1'b1;
        bus_write(2'd3, 32'd4);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'hA5);
        bus_idle();
        capture(40, bits, busyv, found);
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL single_start: no start bit within limit");
        end else begin
            tests_run++;
            if (bits[39:0] !== expw) begin
                tests_failed++;
                $display("FAIL single_wave: got %h expected %h", bits[39:0], expw);
            end
            tests_run++;
            if (busyv[39:0] !== 40'h7F_FFFF_FFFF) begin
                tests_failed++;
                $display("FAIL single_busy: got %h expected 7fffffffff", busyv[39:0]);
            end
        end
        bus_read(2'd1, v);
        tests_run++;
        if (v !== 32'h1) begin
            tests_failed++;
            $display("FAIL single_status_after: got %h expected 00000001", v);
        end
    endtask

    task automatic test_overflow();
        logic [127:0] bits, busyv;
        logic [31:0]  v;
        logic [7:0]   got, exp;
        int           mcount;
        bit           found, quiet;
        mcount = 0;
        bus_write(2'd2, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            bus_write(2'd0, 32'(i));
            if (mcount < 4) begin
                sb.push_back(8'(i));
                mcount++;
            end
        end
        bus_idle();
        bus_read(2'd1, v);
        tests_run++;
        if (v !== 32'h4A) begin
            tests_failed++;
            $display("FAIL ovf_status: got %h expected 0000004a", v);
        end
        bus_write(2'd1, 32'h0);
        bus_idle();
        bus_read(2'd1, v);
        tests_run++;
        if (v !== 32'h42) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %h expected 00000042", v);
        end
        bus_write(2'd3, 32'd4);
        bus_write(2'd2, 32'd1);
        bus_idle();
        for (int f = 0; f < 4; f++) begin
            capture(40, bits, busyv, found);
            tests_run++;
            if (!found || sb.size() == 0) begin
                tests_failed++;
                $display("FAIL ovf_frame%0d: found=%0d queued=%0d expected a frame", f, found,
                         sb.size());
            end else begin
                for (int k = 0; k < 8; k++) got[k] = bits[4*(k+1) + 2];
                exp = sb.pop_front();
                if (got !== exp || bits[3:0] !== 4'h0 || bits[39:36] !== 4'hF) begin
                    tests_failed++;
                    $display("FAIL ovf_frame%0d: got %h start=%b stop=%b expected %h", f, got,
                             bits[3:0], bits[39:36], exp);
                end
            end
        end
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL ovf_no_fifth: got activity on tx expected idle");
        end
        bus_read(2'd1, v);
        tests_run++;
        if (v !== 32'h1) begin
            tests_failed++;
            $display("FAIL ovf_status_end: got %h expected 00000001", v);
        end
    endtask

    task automatic test_interrupt();
        bit seen_busy, int_bad, fell;
        seen_busy = 1'b0;
        int_bad   = 1'b0;
        fell      = 1'b0;
        bus_write(2'd2, 32'd3);
        bus_write(2'd3, 32'd2);
        bus_write(2'd0, 32'h3C);
        bus_idle();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (data_out[2] === 1'b1) begin
                seen_busy = 1'b1;
                if (int_request !== 1'b0) int_bad = 1'b1;
            end else if (seen_busy) begin
                fell = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!fell || int_bad) begin
            tests_failed++;
            $display("FAIL int_during_frame: got fell=%0d int_seen=%0d expected fell=1 int_seen=0",
                     fell, int_bad);
        end
        tests_run++;
        if (int_request !== 1'b0) begin
            tests_failed++;
            $display("FAIL int_at_busy_fall: got %b expected 0", int_request);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (int_request !== 1'b1) begin
            tests_failed++;
            $display("FAIL int_rise: got %b expected 1", int_request);
        end
        bus_write(2'd2, 32'd1);
        bus_idle();
        @(negedge clk);
        #1;
        tests_run++;
        if (int_request !== 1'b0) begin
            tests_failed++;
            $display("FAIL int_clear: got %b expected 0", int_request);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] bits, busyv, expv;
        logic [7:0]   vals [6];
        logic [7:0]   b;
        logic [31:0]  v;
        int           pos;
        bit           found;
        vals = '{8'hC3, 8'h18, 8'h7E, 8'h01, 8'hF0, 8'h96};
        fork
            begin
                bus_write(2'd2, 32'd0);
                bus_write(2'd3, 32'd1);
                for (int i = 0; i < 4; i++) begin
                    bus_write(2'd0, {24'd0, vals[i]});
                    sb.push_back(vals[i]);
                end
                bus_write(2'd2, 32'd1);
                // Lands on the full FIFO in the same cycle as the first pop
                bus_write(2'd0, {24'd0, vals[4]});
                sb.push_back(vals[4]);
                bus_idle();
                repeat (14) @(negedge clk);
                bus_write(2'd0, {24'd0, vals[5]});
                sb.push_back(vals[5]);
                bus_idle();
            end
            begin
                capture(65, bits, busyv, found);
            end
        join
        expv = '0;
        pos  = 0;
        tests_run++;
        if (!found || sb.size() != 6) begin
            tests_failed++;
            $display("FAIL b2b_setup: found=%0d queued=%0d expected found=1 queued=6", found,
                     sb.size());
            sb.delete();
        end else begin
            for (int k = 0; k < 6; k++) begin
                b = sb.pop_front();
                expv[pos] = 1'b0;
                pos = pos + 1;
                for (int j = 0; j < 8; j++) begin
                    expv[pos] = b[j];
                    pos = pos + 1;
                end
                expv[pos] = 1'b1;
                pos = pos + 1;
                if (k < 5) begin
                    expv[pos] = 1'b1;
                    pos = pos + 1;
                end
            end
            tests_run++;
            if (bits[64:0] !== expv[64:0]) begin
                tests_failed++;
                $display("FAIL b2b_wave: got %h expected %h", bits[64:0], expv[64:0]);
            end
        end
        bus_read(2'd1, v);
        tests_run++;
        if (v !== 32'h1) begin
            tests_failed++;
            $display("FAIL b2b_status: got %h expected 00000001", v);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        bit          found, quiet;
        found = 1'b0;
        bus_write(2'd3, 32'd4);
        bus_write(2'd0, 32'h52);
        sb.push_back(8'h52);
        bus_write(2'd0, 32'h77);
        sb.push_back(8'h77);
        bus_idle();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL rst_mid_start: no start bit within limit");
        end
        repeat (17) begin
            @(negedge clk);
            #1;
        end
        tests_run++;
        if (tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_bit3: got %b expected 0", tx);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_tx: got %b expected 1", tx);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_read(2'd1, v);
        tests_run++;
        if (v !== 32'h1) begin
            tests_failed++;
            $display("FAIL rst_mid_status: got %h expected 00000001", v);
        end
        bus_read(2'd3, v);
        tests_run++;
        if (v !== 32'd434) begin
            tests_failed++;
            $display("FAIL rst_mid_div: got %0d expected 434", v);
        end
        bus_read(2'd2, v);
        tests_run++;
        if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_ctrl: got %h expected 0", v);
        end
        bus_write(2'd2, 32'd1);
        bus_idle();
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL rst_mid_residual: got activity on tx expected idle");
        end
        bus_read(2'd1, v);
        tests_run++;
        if (v !== 32'h1) begin
            tests_failed++;
            $display("FAIL rst_mid_status_end: got %h expected 00000001", v);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_interrupt();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
